// File: rtl/lcd_cntrl_pkg.sv
// Shared types and constants for the HD44780 init sequencer.
package lcd_cntrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_ISSUE,
    ST_DELAY,
    ST_RUN,
    ST_HOST_WAIT
  } state_e;

  // {RS,RWB,DB7..DB0}; all-ones is never a legal instruction, used as idle pattern
  localparam logic [9:0] INSTR_NOP   = 10'h3FF;
  localparam logic [9:0] INSTR_FSET  = 10'h030;  // function set, 8-bit interface
  localparam logic [9:0] INSTR_DCTL  = 10'h008;  // display on/off control
  localparam logic [9:0] INSTR_CLEAR = 10'h001;  // clear display
  localparam logic [9:0] INSTR_ENTRY = 10'h004;  // entry mode set

  // Wait times in microseconds
  localparam int unsigned US_PWR_ON = 15000;
  localparam int unsigned US_4100   = 4100;
  localparam int unsigned US_100    = 100;
  localparam int unsigned US_40     = 40;
  localparam int unsigned US_1520   = 1520;

  // Clear display (DB0) and Return home (DB1x) are the only slow instructions
  function automatic logic is_clear_home(input logic [9:0] instr);
    return (instr[9:2] == 8'h00) && (instr[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/lcd_us_timer.sv
// Microsecond down-timer: prescaler divides clk_i to 1 us ticks, counter
// counts loaded microseconds. expired_o pulses in the cycle exactly
// us_i*CLK_PER_US cycles after the load cycle.
module lcd_us_timer #(
  parameter int CLK_PER_US = 100,
  parameter int US_WIDTH   = 14
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                load_i,
  input  logic [US_WIDTH-1:0] us_i,
  output logic                expired_o
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

  logic [PW-1:0]       pre_q, pre_d;
  logic [US_WIDTH-1:0] cnt_q, cnt_d;
  logic                tick;

  // Prescaler wraps each microsecond and restarts on load; counter parks at 0
  always_comb begin
    tick  = (pre_q == PW'(CLK_PER_US - 1));
    pre_d = tick ? '0 : pre_q + PW'(1);
    cnt_d = cnt_q;
    if (tick && (cnt_q != '0)) cnt_d = cnt_q - US_WIDTH'(1);
    if (load_i) begin
      pre_d = '0;
      cnt_d = us_i;
    end
  end

  assign expired_o = tick && (cnt_q == US_WIDTH'(1));

  // Timer state registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pre_q <= '0;
      cnt_q <= '0;
    end else begin
      pre_q <= pre_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/lcd_init_sequencer.sv
// HD44780 power-on init sequencer with host pass-through once initialised.
// Outputs are decoded combinationally from state so an async reset forces
// them to idle values immediately.
module lcd_init_sequencer
  import lcd_cntrl_pkg::*;
#(
  parameter int INSTR_WIDTH = 10,
  parameter int CLK_PER_US  = 100,
  parameter int US_WIDTH    = 14
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   start_i,
  input  logic [1:0]             cfg_nf_i,
  input  logic [1:0]             cfg_entry_i,
  input  logic [2:0]             cfg_disp_i,
  input  logic [INSTR_WIDTH-1:0] host_instr_i,
  input  logic                   host_valid_i,
  output logic                   host_ready_o,
  output logic [INSTR_WIDTH-1:0] phy_instr_o,
  output logic                   phy_valid_o,
  input  logic                   phy_ready_i,
  output logic                   init_done_o,
  output logic                   busy_o
);

  state_e              state_q, state_d;
  logic [2:0]          step_q, step_d;
  logic [1:0]          nf_q, nf_d, entry_q, entry_d;
  logic [2:0]          disp_q, disp_d;
  logic                tmr_load, tmr_exp, restart;
  logic [US_WIDTH-1:0] tmr_us, rom_us;
  logic [9:0]          rom_instr;

  lcd_us_timer #(
    .CLK_PER_US (CLK_PER_US),
    .US_WIDTH   (US_WIDTH)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .load_i    (tmr_load),
    .us_i      (tmr_us),
    .expired_o (tmr_exp)
  );

  // Init ROM: instruction and post-handshake wait for the current step
  always_comb begin
    rom_instr = INSTR_FSET;
    rom_us    = US_WIDTH'(US_40);
    unique case (step_q)
      3'd0:    rom_us = US_WIDTH'(US_4100);
      3'd1:    rom_us = US_WIDTH'(US_100);
      3'd3:    rom_instr = INSTR_FSET | {6'b0, nf_q, 2'b00};
      3'd4:    rom_instr = INSTR_DCTL;
      3'd5: begin
        rom_instr = INSTR_CLEAR;
        rom_us    = US_WIDTH'(US_1520);
      end
      3'd6:    rom_instr = INSTR_ENTRY | {8'b0, entry_q};
      3'd7:    rom_instr = INSTR_DCTL | {7'b0, disp_q};
      default: ;
    endcase
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    step_d       = step_q;
    nf_d         = nf_q;
    entry_d      = entry_q;
    disp_d       = disp_q;
    tmr_load     = 1'b0;
    tmr_us       = '0;
    restart      = 1'b0;
    phy_valid_o  = 1'b0;
    phy_instr_o  = {INSTR_WIDTH{1'b1}};
    host_ready_o = 1'b0;
    init_done_o  = 1'b0;
    unique case (state_q)
      ST_IDLE:     restart = start_i;
      ST_PWR_WAIT: if (tmr_exp) begin
        state_d = ST_ISSUE;
        step_d  = '0;
      end
      ST_ISSUE: begin
        phy_valid_o = 1'b1;
        phy_instr_o = INSTR_WIDTH'(rom_instr);
        if (phy_ready_i) begin
          state_d  = ST_DELAY;
          tmr_load = 1'b1;
          tmr_us   = rom_us;
        end
      end
      ST_DELAY: if (tmr_exp) begin
        if (step_q == 3'd7) state_d = ST_RUN;
        else begin
          step_d  = step_q + 3'd1;
          state_d = ST_ISSUE;
        end
      end
      ST_RUN: begin
        init_done_o = 1'b1;
        // a restart wins over a pending host instruction, which stays unaccepted
        if (start_i) restart = 1'b1;
        else begin
          phy_valid_o  = host_valid_i;
          phy_instr_o  = host_instr_i;
          host_ready_o = phy_ready_i;
          if (host_valid_i && phy_ready_i && is_clear_home(10'(host_instr_i))) begin
            state_d  = ST_HOST_WAIT;
            tmr_load = 1'b1;
            tmr_us   = US_WIDTH'(US_1520);
          end
        end
      end
      ST_HOST_WAIT: begin
        init_done_o = 1'b1;
        // HOST_WAIT reports busy but still honours a restart
        if (start_i) restart = 1'b1;
        else if (tmr_exp) state_d = ST_RUN;
      end
      default: state_d = ST_IDLE;
    endcase
    if (restart) begin
      state_d  = ST_PWR_WAIT;
      step_d   = '0;
      nf_d     = cfg_nf_i;
      entry_d  = cfg_entry_i;
      disp_d   = cfg_disp_i;
      tmr_load = 1'b1;
      tmr_us   = US_WIDTH'(US_PWR_ON);
    end
  end

  assign busy_o = (state_q != ST_IDLE) && (state_q != ST_RUN);

  // State, step and latched configuration registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      nf_q    <= '0;
      entry_q <= '0;
      disp_q  <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      nf_q    <= nf_d;
      entry_q <= entry_d;
      disp_q  <= disp_d;
    end
  end

endmodule

// File: tb/tb_lcd_init_sequencer.sv
// Directed + randomized bench for lcd_init_sequencer. Main DUT runs at
// 1 clock per us to keep full init sequences short; a second instance at
// 4 clocks per us checks prescaled power-on timing.
module tb_lcd_init_sequencer;

  localparam int CP  = 1;
  localparam int CP4 = 4;

  logic       clk = 1'b0;
  logic       rst_n, rst_n4, start, start4, host_valid, phy_ready, ready4;
  logic [1:0] cfg_nf, cfg_entry;
  logic [2:0] cfg_disp;
  logic [9:0] host_instr;
  logic       host_ready_o, phy_valid_o, init_done_o, busy_o;
  logic [9:0] phy_instr_o;
  logic       host_ready4, phy_valid4, init_done4, busy4;
  logic [9:0] phy_instr4;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_init_sequencer #(.INSTR_WIDTH(10), .CLK_PER_US(CP), .US_WIDTH(14)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .cfg_nf_i(cfg_nf), .cfg_entry_i(cfg_entry), .cfg_disp_i(cfg_disp),
    .host_instr_i(host_instr), .host_valid_i(host_valid), .host_ready_o(host_ready_o),
    .phy_instr_o(phy_instr_o), .phy_valid_o(phy_valid_o), .phy_ready_i(phy_ready),
    .init_done_o(init_done_o), .busy_o(busy_o)
  );

  lcd_init_sequencer #(.INSTR_WIDTH(10), .CLK_PER_US(CP4), .US_WIDTH(14)) dut4 (
    .clk_i(clk), .rst_ni(rst_n4), .start_i(start4),
    .cfg_nf_i(cfg_nf), .cfg_entry_i(cfg_entry), .cfg_disp_i(cfg_disp),
    .host_instr_i(host_instr), .host_valid_i(host_valid), .host_ready_o(host_ready4),
    .phy_instr_o(phy_instr4), .phy_valid_o(phy_valid4), .phy_ready_i(ready4),
    .init_done_o(init_done4), .busy_o(busy4)
  );

  // First handshake seen on the prescaled instance
  bit         hs4_seen = 1'b0;
  int         hs4_cyc = 0;
  logic [9:0] hs4_ins = '0;
  always @(negedge clk)
    if (!hs4_seen && rst_n4 && phy_valid4 && ready4) begin
      hs4_seen <= 1'b1;
      hs4_cyc  <= cyc;
      hs4_ins  <= phy_instr4;
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(phy_valid_o), 0);
    chk({tag, "_hready"}, 32'(host_ready_o), 0);
    chk({tag, "_done"}, 32'(init_done_o), 0);
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_instr"}, 32'(phy_instr_o), 32'h3FF);
  endtask

  // Polls (current cycle first) for a PHY handshake; c=-1 on timeout
  task automatic wait_hs(input int budget, output int c, output logic [9:0] ins);
    c = -1;
    ins = '0;
    for (int n = 0; n <= budget; n++) begin
      #1;
      if (phy_valid_o === 1'b1 && phy_ready === 1'b1) begin
        c = cyc;
        ins = phy_instr_o;
        break;
      end
      @(negedge clk);
    end
  endtask

  // Pulse start and follow the init sequence for nsteps handshakes.
  // Each handshake lands (wait_us*CP) delay cycles plus one ISSUE cycle
  // after the previous load cycle; RUN starts 40 us after the last one.
  task automatic do_init(input logic [1:0] nf, input logic [1:0] en, input logic [2:0] dp,
                         input int nsteps, input bit stall3, input bit poke4);
    logic [9:0] exp_i [8];
    int         exp_us [8];
    int         prev, c, n, gap_us;
    logic [9:0] ins;
    bit         ok;
    exp_i  = '{10'h030, 10'h030, 10'h030, 10'h030 | {6'b0, nf, 2'b00}, 10'h008,
               10'h001, 10'h004 | {8'b0, en}, 10'h008 | {7'b0, dp}};
    exp_us = '{4100, 100, 40, 40, 40, 1520, 40, 40};
    @(negedge clk);
    cfg_nf = nf; cfg_entry = en; cfg_disp = dp; start = 1'b1; prev = cyc;
    #1;
    chk("start_no_accept", 32'(host_ready_o), 0);
    chk("start_no_valid", 32'(phy_valid_o), 0);
    @(negedge clk);
    start = 1'b0; cfg_nf = ~nf; cfg_entry = ~en; cfg_disp = ~dp;
    #1;
    chk("start_done_low", 32'(init_done_o), 0);
    chk("start_busy", 32'(busy_o), 1);
    for (int s = 0; s < nsteps; s++) begin
      gap_us = (s == 0) ? 15000 : exp_us[s-1];
      if (stall3 && s == 3) begin
        n = 0;
        while (phy_valid_o !== 1'b1 && n < gap_us*CP + 10) begin @(negedge clk); #1; n++; end
        chk("issue3_entry", cyc - prev, gap_us*CP + 1);
        ok = 1'b1;
        repeat (50) begin
          if (!(phy_valid_o === 1'b1 && phy_instr_o === exp_i[3])) ok = 1'b0;
          @(negedge clk); #1;
        end
        chk("stall3_stable", 32'(ok), 1);
        phy_ready = 1'b1;
        wait_hs(10, c, ins);
        chk("stall3_instr", 32'(ins), 32'(exp_i[3]));
      end else begin
        wait_hs(gap_us*CP + 10, c, ins);
        chk($sformatf("hs%0d_gap", s), c - prev, gap_us*CP + 1);
        chk($sformatf("hs%0d_instr", s), 32'(ins), 32'(exp_i[s]));
      end
      prev = c;
      @(negedge clk); #1;
      chk($sformatf("hs%0d_single", s), 32'(phy_valid_o), 0);
      if (stall3 && s == 2) phy_ready = 1'b0;
      if (poke4 && s == 4) begin
        start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        chk("poke4_busy", 32'(busy_o), 1);
      end
    end
    if (nsteps == 8) begin
      n = 0;
      while (init_done_o !== 1'b1 && n < 40*CP + 10) begin @(negedge clk); #1; n++; end
      chk("done_rise", cyc - prev, 40*CP + 1);
      chk("run_not_busy", 32'(busy_o), 0);
    end
  endtask

  // Send one host instruction in RUN; Clear/Home accepted -> 1520 us hold-off
  task automatic host_send(input logic [9:0] ins, input logic rdy);
    bit blk;
    int n;
    blk = rdy && ((ins >> 2) == 10'd0) && (ins != 10'd0);
    @(negedge clk);
    host_instr = ins; host_valid = 1'b1; phy_ready = rdy;
    #1;
    chk("pass_instr", 32'(phy_instr_o), 32'(ins));
    chk("pass_valid", 32'(phy_valid_o), 1);
    chk("pass_ready", 32'(host_ready_o), 32'(rdy));
    @(negedge clk);
    host_instr = 10'h241; phy_ready = 1'b1; host_valid = blk;
    #1;
    if (blk) begin
      chk("hw_valid_gated", 32'(phy_valid_o), 0);
      chk("hw_done_high", 32'(init_done_o), 1);
      n = 0;
      while (host_ready_o !== 1'b1 && n < 1520*CP + 10) begin n++; @(negedge clk); #1; end
      chk("hw_len", n, 1520*CP);
      chk("hw_release_pass", 32'(phy_valid_o), 1);
      @(negedge clk);
      host_valid = 1'b0;
    end else begin
      chk("no_hold", 32'(host_ready_o), 1);
      host_valid = 1'b0;
    end
  endtask

  initial begin
    logic [1:0] nf, en;
    logic [2:0] dp;
    int         t4, n;
    start = 1'b0; start4 = 1'b0; host_valid = 1'b0; host_instr = '0;
    phy_ready = 1'b1; ready4 = 1'b1;
    cfg_nf = '0; cfg_entry = '0; cfg_disp = '0;
    rst_n = 1'b0; rst_n4 = 1'b0;
    #23;
    chk_reset_outputs("rst");
    @(negedge clk); rst_n = 1'b1; rst_n4 = 1'b1;
    @(negedge clk); start4 = 1'b1; t4 = cyc;
    @(negedge clk); start4 = 1'b0;

    // Directed init with a PHY stall in step3 and an ignored start in step4
    do_init(2'b10, 2'b10, 3'b100, 8, 1'b1, 1'b1);

    // Host pass-through in RUN
    host_send(10'h241, 1'b1);
    host_send(10'h241, 1'b0);
    host_send(10'h001, 1'b1);
    host_send(10'h002, 1'b1);
    host_send(10'h004, 1'b1);
    for (int i = 0; i < 6; i++) host_send({1'b1, 9'($urandom)}, 1'($urandom));
    host_send(10'($urandom), 1'b1);

    // Restart from RUN with an outstanding host request and random cfg
    nf = 2'($urandom); en = 2'($urandom); dp = 3'($urandom);
    host_instr = 10'h241; host_valid = 1'b1;
    do_init(nf, en, dp, 6, 1'b0, 1'b0);

    // Async reset in the middle of the step5 delay
    repeat (100) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk); rst_n = 1'b1; host_valid = 1'b0;
    nf = 2'($urandom); en = 2'($urandom); dp = 3'($urandom);
    do_init(nf, en, dp, 8, 1'b0, 1'b0);

    // Prescaled instance: first handshake after 15000 us at 4 clocks/us
    n = 0;
    while (!hs4_seen && n < 80000) begin @(negedge clk); n++; end
    chk("p4_first_hs", hs4_cyc - t4, 15000*CP4 + 1);
    chk("p4_first_instr", 32'(hs4_ins), 32'h030);
    chk("p4_busy", 32'(busy4), 1);
    chk("p4_not_done", 32'(init_done4), 0);
    chk("p4_no_hready", 32'(host_ready4), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
